// File: rtl/cnn_pkg.sv
// Shared CNN pipeline constants and the argmax FSM state type.
package cnn_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int DATA_WIDTH  = 16;

    localparam logic signed [DATA_WIDTH-1:0] SCORE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COLLECT  = 2'd1,
        ST_FINALIZE = 2'd2,
        ST_DONE     = 2'd3
    } argmax_state_t;

endpackage

// File: rtl/argmax_top2_update.sv
// Combinational top-2 tracker step: folds one (score, index) into the running best/second.
module argmax_top2_update #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic signed [DATA_WIDTH-1:0] best,
    input  logic signed [DATA_WIDTH-1:0] second,
    input  logic        [ADDR_WIDTH-1:0] best_idx,
    input  logic signed [DATA_WIDTH-1:0] data,
    input  logic        [ADDR_WIDTH-1:0] addr,
    output logic signed [DATA_WIDTH-1:0] best_next,
    output logic signed [DATA_WIDTH-1:0] second_next,
    output logic        [ADDR_WIDTH-1:0] best_idx_next
);

    logic win;

    // Equal scores go to the lower index so the result does not depend on arrival order.
    assign win = (data > best) || ((data == best) && (addr < best_idx));

    always_comb begin
        best_next     = best;
        second_next   = second;
        best_idx_next = best_idx;
        if (win) begin
            second_next   = best;
            best_next     = data;
            best_idx_next = addr;
        end else if (data >= second) begin
            second_next = data;
        end
    end

endmodule

// File: rtl/argmax_classifier.sv
// Streaming argmax over the FC output write stream: predicted class, score and top-1/top-2 margin.
module argmax_classifier #(
    parameter int NUM_CLASSES = cnn_pkg::NUM_CLASSES,
    parameter int DATA_WIDTH  = cnn_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH  = $clog2(NUM_CLASSES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic [ADDR_WIDTH-1:0] class_idx,
    output logic [DATA_WIDTH-1:0] max_val,
    output logic [DATA_WIDTH:0]   margin,
    output logic                  result_valid,
    output logic                  busy,
    output logic                  error
);

    import cnn_pkg::*;

    localparam logic signed [DATA_WIDTH-1:0] SCORE_FLOOR = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    argmax_state_t                state_reg;
    logic [NUM_CLASSES-1:0]       bitmap_reg;
    logic signed [DATA_WIDTH-1:0] best_reg;
    logic signed [DATA_WIDTH-1:0] second_reg;
    logic [ADDR_WIDTH-1:0]        best_idx_reg;
    logic                         err_reg;
    logic [ADDR_WIDTH-1:0]        class_idx_reg;
    logic [DATA_WIDTH-1:0]        max_val_reg;
    logic [DATA_WIDTH:0]          margin_reg;
    logic                         result_valid_reg;
    logic                         error_reg;

    logic signed [DATA_WIDTH-1:0] best_next;
    logic signed [DATA_WIDTH-1:0] second_next;
    logic [ADDR_WIDTH-1:0]        best_idx_next;
    logic [NUM_CLASSES-1:0]       hit;
    logic                         in_range;
    logic                         duplicate;
    logic                         set_bad;
    logic [DATA_WIDTH:0]          margin_next;

    // One-hot decode of the incoming address; an all-zero vector means out of range.
    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_hit
        assign hit[gi] = (in_addr == ADDR_WIDTH'(gi));
    end

    assign in_range  = |hit;
    assign duplicate = |(hit & bitmap_reg);
    assign set_bad   = err_reg | ~(&bitmap_reg);

    // Sign-extend both operands so best - second never overflows.
    assign margin_next = {best_reg[DATA_WIDTH-1], best_reg} - {second_reg[DATA_WIDTH-1], second_reg};

    argmax_top2_update #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_top2 (
        .best          (best_reg),
        .second        (second_reg),
        .best_idx      (best_idx_reg),
        .data          ($signed(in_data)),
        .addr          (in_addr),
        .best_next     (best_next),
        .second_next   (second_next),
        .best_idx_next (best_idx_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            bitmap_reg       <= '0;
            best_reg         <= '0;
            second_reg       <= '0;
            best_idx_reg     <= '0;
            err_reg          <= 1'b0;
            class_idx_reg    <= '0;
            max_val_reg      <= '0;
            margin_reg       <= '0;
            result_valid_reg <= 1'b0;
            error_reg        <= 1'b0;
        end else begin
            result_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        best_reg     <= SCORE_FLOOR;
                        second_reg   <= SCORE_FLOOR;
                        best_idx_reg <= '0;
                        bitmap_reg   <= '0;
                        err_reg      <= 1'b0;
                        error_reg    <= 1'b0;
                        state_reg    <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (in_valid) begin
                        if (!in_range || duplicate) begin
                            err_reg <= 1'b1;
                        end else begin
                            bitmap_reg   <= bitmap_reg | hit;
                            best_reg     <= best_next;
                            second_reg   <= second_next;
                            best_idx_reg <= best_idx_next;
                        end
                    end
                    if (in_last) begin
                        state_reg <= ST_FINALIZE;
                    end
                end
                ST_FINALIZE: begin
                    // Results land as DONE is entered so result_valid is high during DONE.
                    err_reg          <= set_bad;
                    class_idx_reg    <= best_idx_reg;
                    max_val_reg      <= best_reg;
                    margin_reg       <= margin_next;
                    error_reg        <= set_bad;
                    result_valid_reg <= 1'b1;
                    state_reg        <= ST_DONE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign class_idx    = class_idx_reg;
    assign max_val      = max_val_reg;
    assign margin       = margin_reg;
    assign result_valid = result_valid_reg;
    assign error        = error_reg;
    assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier: hand-computed score sets, latency and error cases.
module tb_argmax_classifier;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] in_data;
    logic [3:0]  in_addr;
    logic        in_valid;
    logic        in_last;
    logic [3:0]  class_idx;
    logic [15:0] max_val;
    logic [16:0] margin;
    logic        result_valid;
    logic        busy;
    logic        error;

    int n_compared;
    int n_mismatched;
    int sa [0:15];
    int sd [0:15];

    argmax_classifier #(
        .NUM_CLASSES (10),
        .DATA_WIDTH  (16),
        .ADDR_WIDTH  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_data      (in_data),
        .in_addr      (in_addr),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .class_idx    (class_idx),
        .max_val      (max_val),
        .margin       (margin),
        .result_valid (result_valid),
        .busy         (busy),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int observed, input int expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end else begin
            $display("ok   %s: %0d", tag, observed);
        end
    endtask

    // Pulse start, then stream n samples from sa/sd; in_last rides with the final sample.
    task automatic run_set(input int n, input int start_at);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_val("busy_after_start", int'(busy), 1);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_addr  = 4'(sa[i]);
            in_data  = 16'(sd[i]);
            in_last  = (i == n - 1);
            start    = (i == start_at);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
    endtask

    // Latency counted from the cycle in_last was high.
    task automatic expect_result(input string tag, input int cls, input int mx,
                                 input int mg, input int er);
        int cnt;
        bit seen;
        cnt  = 1;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(posedge clk); #1;
            cnt++;
            if (result_valid) seen = 1'b1;
        end
        check_val({tag, "_rv_seen"}, int'(seen), 1);
        if (seen) begin
            check_val({tag, "_latency"}, cnt, 2);
            check_val({tag, "_class"}, int'(class_idx), cls);
            check_val({tag, "_max"}, int'($signed(max_val)), mx);
            check_val({tag, "_margin"}, int'(margin), mg);
            check_val({tag, "_error"}, int'(error), er);
            @(posedge clk); #1;
            check_val({tag, "_rv_pulse"}, int'(result_valid), 0);
            check_val({tag, "_idle"}, int'(busy), 0);
        end
    endtask

    task automatic load_set1();
        int v [0:9];
        v = '{5, -3, 100, 7, 0, 1, 2, 3, 4, 6};
        for (int i = 0; i < 10; i++) begin
            sa[i] = i;
            sd[i] = v[i];
        end
    endtask

    initial begin
        int rv_count;
        int v9 [0:8];
        int a9 [0:8];
        n_compared   = 0;
        n_mismatched = 0;
        reset    = 1'b1;
        start    = 1'b0;
        in_data  = '0;
        in_addr  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_class", int'(class_idx), 0);
        check_val("rst_max", int'(max_val), 0);
        check_val("rst_margin", int'(margin), 0);
        check_val("rst_rv", int'(result_valid), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_error", int'(error), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Samples in IDLE must be ignored.
        in_valid = 1'b1; in_addr = 4'd5; in_data = 16'd30000;
        @(posedge clk); #1;
        in_valid = 1'b0;

        // 1: in-order set
        load_set1();
        run_set(10, -1);
        expect_result("t1", 2, 100, 93, 0);

        // 2: reverse order, tie between 3 and 7
        for (int i = 0; i < 10; i++) begin
            sa[i] = 9 - i;
            sd[i] = ((9 - i) == 3 || (9 - i) == 7) ? 50 : 0;
        end
        run_set(10, -1);
        expect_result("t2", 3, 50, 0, 0);

        // 3: all at the most negative score
        for (int i = 0; i < 10; i++) begin
            sa[i] = i;
            sd[i] = -32768;
        end
        run_set(10, -1);
        expect_result("t3", 0, -32768, 0, 0);

        // 4: class 4 missing
        a9 = '{0, 1, 2, 3, 5, 6, 7, 8, 9};
        v9 = '{3, 80, 10, -5, 20, 0, -100, 7, 60};
        for (int i = 0; i < 9; i++) begin
            sa[i] = a9[i];
            sd[i] = v9[i];
        end
        run_set(9, -1);
        expect_result("t4", 1, 80, 20, 1);

        // 4b: clean set afterwards; error clears on start
        load_set1();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_val("t4b_err_clr_on_start", int'(error), 0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_addr  = 4'(sa[i]);
            in_data  = 16'(sd[i]);
            in_last  = (i == 9);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        expect_result("t4b", 2, 100, 93, 0);

        // 5: duplicate addr 2 (larger) and out-of-range addr 12
        load_set1();
        sa[10] = 9;  sd[10] = 6;
        sa[3]  = 2;  sd[3]  = 200;
        sa[10] = 3;  sd[10] = 7;
        sa[11] = 12; sd[11] = 300;
        sa[12] = 9;  sd[12] = 6;
        // order: 0,1,2,dup2,4..8,3,12,9
        sa[9] = 8; sd[9] = 4;
        for (int i = 4; i < 9; i++) begin
            sa[i] = i;
            sd[i] = (i == 4) ? 0 : i - 4;
        end
        sa[8] = 8; sd[8] = 4;
        sa[9] = 3; sd[9] = 7;
        sa[10] = 12; sd[10] = 300;
        sa[11] = 9; sd[11] = 6;
        run_set(12, -1);
        expect_result("t5", 2, 100, 93, 1);

        // 6: reset mid-COLLECT
        load_set1();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_addr  = 4'(sa[i]);
            in_data  = 16'(sd[i]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        rv_count = 0;
        for (int k = 0; k < 6; k++) begin
            if (result_valid) rv_count++;
            @(posedge clk); #1;
        end
        check_val("t6_no_rv", rv_count, 0);
        check_val("t6_class", int'(class_idx), 0);
        check_val("t6_max", int'(max_val), 0);
        check_val("t6_margin", int'(margin), 0);
        check_val("t6_error", int'(error), 0);
        check_val("t6_busy", int'(busy), 0);

        // 6b: full set with start asserted mid-stream (ignored)
        load_set1();
        run_set(10, 5);
        expect_result("t6b", 2, 100, 93, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
